// File: rtl/seg_scan6.sv
// rtl/seg_scan6.sv - six-digit multiplexed 7-segment scan driver with blink and leading-zero blanking
module seg_scan6 #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int SCAN_HZ        = 6_000,
    parameter int DEAD_CYC       = 16,
    parameter int BLINK_HZ       = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] bcd_in,
    input  logic        load,
    input  logic [5:0]  dp_mask,
    input  logic [5:0]  blink_mask,
    input  logic        lz_blank,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [5:0]  dig
);

    localparam int DIV     = CLK_HZ / SCAN_HZ;
    localparam int HB      = CLK_HZ / (2 * BLINK_HZ);
    localparam int PC_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BC_W    = (HB > 1) ? $clog2(HB) : 1;
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);
    localparam logic [6:0] SEG_OFF = {7{SEG_INV}};
    localparam logic [5:0] DIG_OFF = {6{DIG_INV}};

    logic [PC_W-1:0] r_pc;
    logic [2:0]      r_idx;
    logic [BC_W-1:0] r_bc;
    logic            r_bp;
    logic [23:0]     r_sh;
    logic [6:0]      r_seg;
    logic            r_dp;
    logic [5:0]      r_dig;

    logic            w_pc_wrap;
    logic            w_bc_wrap;
    logic [3:0]      w_d;
    logic            w_dp_bit;
    logic            w_bl_bit;
    logic [5:0]      w_onehot;
    logic [6:0]      w_font;
    logic            w_blank;
    logic            w_en;
    logic [6:0]      w_seg_n;
    logic            w_dp_n;
    logic [5:0]      w_dig_n;

    assign w_pc_wrap = (r_pc == PC_W'(DIV - 1));
    assign w_bc_wrap = (r_bc == BC_W'(HB - 1));

    // Per-digit selection of the shadow nibble and its live mask bits
    always_comb begin
        w_d      = 4'd0;
        w_dp_bit = 1'b0;
        w_bl_bit = 1'b0;
        w_onehot = 6'd0;
        case (r_idx)
            3'd0: begin w_d = r_sh[3:0];   w_dp_bit = dp_mask[0]; w_bl_bit = blink_mask[0]; w_onehot = 6'b000001; end
            3'd1: begin w_d = r_sh[7:4];   w_dp_bit = dp_mask[1]; w_bl_bit = blink_mask[1]; w_onehot = 6'b000010; end
            3'd2: begin w_d = r_sh[11:8];  w_dp_bit = dp_mask[2]; w_bl_bit = blink_mask[2]; w_onehot = 6'b000100; end
            3'd3: begin w_d = r_sh[15:12]; w_dp_bit = dp_mask[3]; w_bl_bit = blink_mask[3]; w_onehot = 6'b001000; end
            3'd4: begin w_d = r_sh[19:16]; w_dp_bit = dp_mask[4]; w_bl_bit = blink_mask[4]; w_onehot = 6'b010000; end
            3'd5: begin w_d = r_sh[23:20]; w_dp_bit = dp_mask[5]; w_bl_bit = blink_mask[5]; w_onehot = 6'b100000; end
            default: ;
        endcase
    end

    always_comb begin
        w_font = 7'h40;
        case (w_d)
            4'd0: w_font = 7'h3F;
            4'd1: w_font = 7'h06;
            4'd2: w_font = 7'h5B;
            4'd3: w_font = 7'h4F;
            4'd4: w_font = 7'h66;
            4'd5: w_font = 7'h6D;
            4'd6: w_font = 7'h7D;
            4'd7: w_font = 7'h07;
            4'd8: w_font = 7'h7F;
            4'd9: w_font = 7'h6F;
            default: w_font = 7'h40;
        endcase
    end

    assign w_blank = (r_bp & w_bl_bit) | ((r_idx == 3'd5) & lz_blank & (w_d == 4'd0));
    assign w_en    = ~w_blank & (r_pc >= PC_W'(DEAD_CYC));

    // Lit-sense values converted to pin polarity in one place
    assign w_seg_n = (w_blank ? 7'd0 : w_font) ^ SEG_OFF;
    assign w_dp_n  = (~w_blank & w_dp_bit) ^ SEG_INV;
    assign w_dig_n = (w_en ? w_onehot : 6'd0) ^ DIG_OFF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= '0;
            r_idx <= 3'd0;
            r_bc  <= '0;
            r_bp  <= 1'b0;
            r_sh  <= 24'd0;
            r_seg <= SEG_OFF;
            r_dp  <= SEG_INV;
            r_dig <= DIG_OFF;
        end else begin
            if (w_pc_wrap) begin
                r_pc  <= '0;
                r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            end else begin
                r_pc  <= r_pc + PC_W'(1);
            end
            if (w_bc_wrap) begin
                r_bc <= '0;
                r_bp <= ~r_bp;
            end else begin
                r_bc <= r_bc + BC_W'(1);
            end
            if (load) begin
                r_sh <= bcd_in;
            end
            r_seg <= w_seg_n;
            r_dp  <= w_dp_n;
            r_dig <= w_dig_n;
        end
    end

    assign seg = r_seg;
    assign dp  = r_dp;
    assign dig = r_dig;

endmodule

// File: tb/tb_seg_scan6.sv
// tb/tb_seg_scan6.sv - scoreboard bench for seg_scan6 sampling each digit window mid-way
module tb_seg_scan6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] bcd_in = 24'd0;
    logic        load = 1'b0;
    logic [5:0]  dp_mask = 6'd0;
    logic [5:0]  blink_mask = 6'd0;
    logic        lz_blank = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [5:0]  dig;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt     = 0;
    logic [13:0] exp_q[$];

    logic [5:0] DIGS[6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};

    seg_scan6 #(
        .CLK_HZ(1200), .SCAN_HZ(120), .DEAD_CYC(2), .BLINK_HZ(10),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
        .dp_mask(dp_mask), .blink_mask(blink_mask), .lz_blank(lz_blank),
        .seg(seg), .dp(dp), .dig(dig)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got dig/seg/dp=%h/%h/%b, expected %h/%h/%b",
                     name, act[13:8], act[7:1], act[0], exp[13:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic push(input logic [5:0] d, input logic [6:0] s, input logic p);
        exp_q.push_back({d, s, p});
    endtask

    // Edges since reset release; window w is mid-way at edge 10*w+6
    always @(posedge clk) begin
        if (!rst_n) cnt <= 0;
        else        cnt <= cnt + 1;
    end

    always @(negedge clk) begin
        logic [13:0] e;
        if (rst_n && (cnt % 10 == 6) && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("window%0d", cnt / 10), {dig, seg, dp}, e);
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_hold", {dig, seg, dp}, {6'h3F, 7'h7F, 1'b1});
        end
    endtask

    task automatic release_rst(input logic ld);
        load = ld;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic drain(input string name, input int bound);
        int i = 0;
        while (exp_q.size() > 0 && i < bound) begin
            @(posedge clk);
            #2;
            i++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d windows never seen, 0 required", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete, completion required");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, first-enable timing and digit mapping
        do_reset();
        bcd_in = 24'h235959;
        begin
            logic [6:0] s235959[6] = '{7'h10, 7'h12, 7'h10, 7'h12, 7'h30, 7'h24};
            for (int w = 0; w < 12; w++) push(DIGS[w % 6], s235959[w % 6], 1'b1);
        end
        release_rst(1'b1);
        for (int k = 1; k <= 13; k++) begin
            logic [5:0] e;
            @(negedge clk);
            e = (k >= 3 && k <= 10) ? 6'h3E : (k == 13) ? 6'h3D : 6'h3F;
            check($sformatf("first_en_edge%0d", k), {dig, 8'h00}, {e, 8'h00});
        end
        drain("mapping", 200);

        // Leading-zero blanking on
        do_reset();
        bcd_in = 24'h012345; lz_blank = 1'b1;
        push(6'h3E, 7'h12, 1'b1); push(6'h3D, 7'h19, 1'b1); push(6'h3B, 7'h30, 1'b1);
        push(6'h37, 7'h24, 1'b1); push(6'h2F, 7'h79, 1'b1); push(6'h3F, 7'h7F, 1'b1);
        release_rst(1'b1);
        drain("lz_on", 100);

        // Leading-zero blanking off
        do_reset();
        lz_blank = 1'b0;
        push(6'h3E, 7'h12, 1'b1); push(6'h3D, 7'h19, 1'b1); push(6'h3B, 7'h30, 1'b1);
        push(6'h37, 7'h24, 1'b1); push(6'h2F, 7'h79, 1'b1); push(6'h1F, 7'h40, 1'b1);
        release_rst(1'b1);
        drain("lz_off", 100);

        // Blink on digits 0 and 1: dark for windows 6..11
        do_reset();
        bcd_in = 24'h123456; blink_mask = 6'b000011;
        begin
            logic [6:0] s123456[6] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
            for (int w = 0; w < 18; w++) begin
                if (w >= 6 && w < 12 && (w % 6) < 2) push(6'h3F, 7'h7F, 1'b1);
                else                                  push(DIGS[w % 6], s123456[w % 6], 1'b1);
            end
        end
        release_rst(1'b1);
        drain("blink", 250);

        // Error dash on digit 0, decimal point on digit 2
        do_reset();
        bcd_in = 24'h00000C; blink_mask = 6'd0; dp_mask = 6'b000100;
        push(6'h3E, 7'h3F, 1'b1); push(6'h3D, 7'h40, 1'b1); push(6'h3B, 7'h40, 1'b0);
        push(6'h37, 7'h40, 1'b1); push(6'h2F, 7'h40, 1'b1); push(6'h1F, 7'h40, 1'b1);
        release_rst(1'b1);
        drain("err_dp", 100);

        // Asynchronous reset mid-window on digit 2
        do_reset();
        bcd_in = 24'h235959; dp_mask = 6'd0;
        push(6'h3E, 7'h10, 1'b1); push(6'h3D, 7'h12, 1'b1); push(6'h3B, 7'h10, 1'b1);
        release_rst(1'b1);
        drain("pre_async", 100);
        check("pre_async_dig", {dig, 8'h00}, {6'h3B, 8'h00});
        rst_n = 1'b0;
        #1;
        check("async_reset", {dig, seg, dp}, {6'h3F, 7'h7F, 1'b1});
        repeat (3) @(negedge clk);
        push(6'h3E, 7'h40, 1'b1); push(6'h3D, 7'h40, 1'b1);
        release_rst(1'b0);
        drain("post_async", 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
